// File: rtl/fre_comp_ctrl.sv
// Frame sequencer for receive-side frequency compensation: averages P[d] metrics after a
// preamble, issues one averaged metric, waits out the datapath latency, then forwards one frame.
module fre_comp_ctrl #(
   parameter int unsigned ACC_LOG2  = 3,
   parameter int unsigned FRAME_LEN = 3200,
   parameter int unsigned WAIT_CYC  = 24
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic        SYNC_I,
   input  logic [31:0] MET_I,
   input  logic        MET_I_nd,
   output logic [31:0] FRE_O,
   output logic        FRE_O_nd,
   input  logic [31:0] DAT_I,
   input  logic        CYC_I,
   input  logic        STB_I,
   input  logic        WE_I,
   output logic        ACK_O,
   output logic [31:0] DAT_O,
   output logic        CYC_O,
   output logic        STB_O,
   output logic        WE_O,
   input  logic        ACK_I,
   output logic        BUSY_O,
   output logic        ERR_O
);

   localparam int unsigned AW  = 16 + ACC_LOG2;
   localparam int unsigned MCW = (ACC_LOG2 > 0) ? ACC_LOG2 : 1;
   localparam int unsigned SCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int unsigned WCW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

   localparam logic [MCW-1:0] MET_LAST  = MCW'((1 << ACC_LOG2) - 1);
   localparam logic [SCW-1:0] SMP_LAST  = SCW'(FRAME_LEN - 1);
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ACCUM, S_LOAD, S_WAIT, S_STREAM, S_DRAIN
   } state_t;

   state_t                state, state_nx;
   logic signed [AW-1:0]  acc_re, acc_re_nx, acc_im, acc_im_nx;
   logic [MCW-1:0]        met_cnt, met_cnt_nx;
   logic [WCW-1:0]        wait_cnt, wait_cnt_nx;
   logic [SCW-1:0]        smp_cnt, smp_cnt_nx;
   logic [31:0]           fre_nx, dat_nx;
   logic                  fre_nd_nx, stb_nx, cyc_nx, err_nx;
   logic                  out_halt;

   // Downstream stall blocks upstream acceptance so no sample is overwritten.
   assign out_halt = STB_O & ~ACK_I;
   assign ACK_O    = (state == S_STREAM) & CYC_I & STB_I & WE_I & ~out_halt;
   assign WE_O     = STB_O;

   always_comb begin
      state_nx    = state;
      acc_re_nx   = acc_re;
      acc_im_nx   = acc_im;
      met_cnt_nx  = met_cnt;
      wait_cnt_nx = wait_cnt;
      smp_cnt_nx  = smp_cnt;
      fre_nx      = FRE_O;
      fre_nd_nx   = 1'b0;
      dat_nx      = DAT_O;
      stb_nx      = STB_O;
      cyc_nx      = CYC_O;
      err_nx      = 1'b0;
      case (state)
         S_IDLE: begin
            if (SYNC_I) begin
               state_nx   = S_ACCUM;
               acc_re_nx  = '0;
               acc_im_nx  = '0;
               met_cnt_nx = '0;
            end
         end
         S_ACCUM: begin
            if (MET_I_nd) begin
               acc_re_nx  = acc_re + AW'($signed(MET_I[15:0]));
               acc_im_nx  = acc_im + AW'($signed(MET_I[31:16]));
               met_cnt_nx = met_cnt + MCW'(1);
               // Average is published from the updated sums so it is valid in LOAD.
               if (met_cnt == MET_LAST) begin
                  state_nx  = S_LOAD;
                  fre_nx    = {16'(acc_im_nx >>> ACC_LOG2), 16'(acc_re_nx >>> ACC_LOG2)};
                  fre_nd_nx = 1'b1;
               end
            end
         end
         S_LOAD: begin
            state_nx    = S_WAIT;
            wait_cnt_nx = '0;
         end
         S_WAIT: begin
            if (wait_cnt == WAIT_LAST) begin
               state_nx   = S_STREAM;
               cyc_nx     = 1'b1;
               smp_cnt_nx = '0;
            end else begin
               wait_cnt_nx = wait_cnt + WCW'(1);
            end
         end
         S_STREAM: begin
            if (ACK_O) begin
               dat_nx     = DAT_I;
               stb_nx     = 1'b1;
               smp_cnt_nx = smp_cnt + SCW'(1);
               if (smp_cnt == SMP_LAST) state_nx = S_DRAIN;
            end else if (!out_halt) begin
               stb_nx = 1'b0;
            end
            if (!CYC_I) begin
               err_nx   = 1'b1;
               state_nx = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Close the bus in the same cycle the last pending beat is taken.
            if (!STB_O || ACK_I) begin
               stb_nx   = 1'b0;
               cyc_nx   = 1'b0;
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state    <= S_IDLE;
         acc_re   <= '0;
         acc_im   <= '0;
         met_cnt  <= '0;
         wait_cnt <= '0;
         smp_cnt  <= '0;
         FRE_O    <= '0;
         FRE_O_nd <= 1'b0;
         DAT_O    <= '0;
         STB_O    <= 1'b0;
         CYC_O    <= 1'b0;
         BUSY_O   <= 1'b0;
         ERR_O    <= 1'b0;
      end else begin
         state    <= state_nx;
         acc_re   <= acc_re_nx;
         acc_im   <= acc_im_nx;
         met_cnt  <= met_cnt_nx;
         wait_cnt <= wait_cnt_nx;
         smp_cnt  <= smp_cnt_nx;
         FRE_O    <= fre_nx;
         FRE_O_nd <= fre_nd_nx;
         DAT_O    <= dat_nx;
         STB_O    <= stb_nx;
         CYC_O    <= cyc_nx;
         BUSY_O   <= (state_nx != S_IDLE);
         ERR_O    <= err_nx;
      end
   end

endmodule

// File: tb/tb_fre_comp_ctrl.sv
// Scenario bench for fre_comp_ctrl: averaging, full frames, back-pressure, abort, reset.
module tb_fre_comp_ctrl;

   localparam int FRAME = 3200;
   localparam int WAITC = 24;

   logic        clk = 1'b0;
   logic        RST_I, SYNC_I, MET_I_nd, CYC_I, STB_I, WE_I, ACK_I;
   logic [31:0] MET_I, DAT_I;
   logic [31:0] FRE_O, DAT_O;
   logic        FRE_O_nd, ACK_O, CYC_O, STB_O, WE_O, BUSY_O, ERR_O;

   fre_comp_ctrl #(.ACC_LOG2(3), .FRAME_LEN(FRAME), .WAIT_CYC(WAITC)) dut (
      .CLK_I(clk), .RST_I(RST_I), .SYNC_I(SYNC_I), .MET_I(MET_I), .MET_I_nd(MET_I_nd),
      .FRE_O(FRE_O), .FRE_O_nd(FRE_O_nd), .DAT_I(DAT_I), .CYC_I(CYC_I), .STB_I(STB_I),
      .WE_I(WE_I), .ACK_O(ACK_O), .DAT_O(DAT_O), .CYC_O(CYC_O), .STB_O(STB_O),
      .WE_O(WE_O), .ACK_I(ACK_I), .BUSY_O(BUSY_O), .ERR_O(ERR_O)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   // Event monitor: strobes, errors and CYC_O edges, all written only here.
   int          nd_cnt = 0, nd_cyc = 0, err_cnt = 0, rise_cyc = 0, fall_cyc = 0, we_bad = 0;
   logic [31:0] nd_val = '0;
   logic        cyc_d  = 1'b0;
   always @(negedge clk) begin
      if (FRE_O_nd === 1'b1) begin nd_cnt++; nd_cyc = cycle; nd_val = FRE_O; end
      if (ERR_O === 1'b1) err_cnt++;
      if (CYC_O === 1'b1 && cyc_d !== 1'b1) rise_cyc = cycle;
      if (CYC_O !== 1'b1 && cyc_d === 1'b1) fall_cyc = cycle;
      cyc_d = CYC_O;
      if (WE_O !== STB_O) we_bad++;
   end

   logic [31:0] exp_q [$];
   int          ack_cnt, ds_cnt, stall_bad, first_ack, last_ack, last_xfer, sb_prints = 0;
   bit          to_flag;
   logic [71:0] rst_snap;
   logic        busy_at_sync, busy_after_sync;
   int          last_met_cyc;

   function automatic logic [15:0] avg8(input logic [15:0] v [8]);
      int s, q;
      s = 0;
      for (int i = 0; i < 8; i++) s += int'($signed(v[i]));
      q = s / 8;
      if ((s % 8) != 0 && s < 0) q = q - 1;
      return 16'(q);
   endfunction

   task automatic preamble(input logic [15:0] re [8], input logic [15:0] im [8],
                           input bit gaps, input bit poke_wait);
      @(posedge clk); #1; SYNC_I = 1'b1;
      @(negedge clk); busy_at_sync = BUSY_O;
      @(posedge clk); #1; SYNC_I = 1'b0;
      @(negedge clk); busy_after_sync = BUSY_O;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1; MET_I = {im[i], re[i]}; MET_I_nd = 1'b1;
         @(negedge clk); last_met_cyc = cycle;
         if (gaps) begin @(posedge clk); #1; MET_I_nd = 1'b0; MET_I = $urandom; end
      end
      @(posedge clk); #1; MET_I_nd = 1'b0;
      if (poke_wait) begin
         @(posedge clk); #1; MET_I = 32'h7fff7fff; MET_I_nd = 1'b1;
         repeat (3) @(posedge clk);
         #1; MET_I_nd = 1'b0;
      end
   endtask

   // Upstream master + downstream slave; scoreboard pushes on accept, pops on delivery.
   task automatic run_stream(input int abort_after, input int stall_at, input int reset_at,
                             input bit poke, input logic [31:0] base);
      int k, budget, stall_left, rst_wait;
      bit stall_done, rst_done;
      logic [31:0] hold_dat, e;
      logic hold_stb;
      k = 0; budget = 0; stall_left = 0; rst_wait = 0; stall_done = 0; rst_done = 0;
      hold_dat = '0; hold_stb = 1'b0;
      ack_cnt = 0; ds_cnt = 0; stall_bad = 0; first_ack = -1; last_ack = 0; last_xfer = 0;
      to_flag = 0; rst_snap = '1;
      exp_q.delete();
      while (1) begin
         if (budget >= 20000) begin to_flag = 1; break; end
         budget++;
         @(posedge clk); #1;
         RST_I = 1'b0;
         if (!rst_done && reset_at >= 0 && k == reset_at) begin
            RST_I = 1'b1; rst_done = 1; rst_wait = 1;
         end
         if (!stall_done && k == stall_at) begin stall_left = 5; stall_done = 1; end
         ACK_I  = (stall_left == 0);
         CYC_I  = (abort_after < 0) || (k < abort_after);
         STB_I  = CYC_I;
         WE_I   = CYC_I;
         DAT_I  = base + 32'(k);
         SYNC_I = poke && (k == 50);
         @(negedge clk);
         if (rst_wait == 2) begin
            rst_snap = {FRE_O, FRE_O_nd, DAT_O, CYC_O, STB_O, WE_O, ACK_O, BUSY_O, ERR_O};
            rst_wait = 0;
         end else if (rst_wait == 1) rst_wait = 2;
         if (stall_left > 0) begin
            if (ACK_O !== 1'b0) stall_bad++;
            if (stall_left == 5) begin
               hold_dat = DAT_O; hold_stb = STB_O;
               if (hold_stb !== 1'b1) stall_bad++;
            end else if (DAT_O !== hold_dat || STB_O !== hold_stb) stall_bad++;
            stall_left--;
         end
         if (STB_O === 1'b1 && ACK_I === 1'b1) begin
            ds_cnt++; last_xfer = cycle;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               if (sb_prints < 10) $display("FAIL sb_extra got=%h exp=<none>", DAT_O);
               sb_prints++;
            end else begin
               e = exp_q.pop_front();
               if (DAT_O !== e) begin
                  bad++;
                  if (sb_prints < 10) $display("FAIL sb_dat got=%h exp=%h", DAT_O, e);
                  sb_prints++;
               end
            end
         end
         if (ACK_O === 1'b1) begin
            exp_q.push_back(DAT_I);
            if (first_ack < 0) first_ack = cycle;
            last_ack = cycle; k++; ack_cnt++;
         end
         if (BUSY_O !== 1'b1) break;
      end
      @(posedge clk); #1;
      CYC_I = 0; STB_I = 0; WE_I = 0; ACK_I = 1; SYNC_I = 0; RST_I = 0;
   endtask

   task automatic test_reset;
      RST_I = 1; SYNC_I = 0; MET_I = '0; MET_I_nd = 0; DAT_I = '0;
      CYC_I = 0; STB_I = 0; WE_I = 0; ACK_I = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (FRE_O !== 32'h0) begin bad++; $display("FAIL rst_fre got=%h exp=0", FRE_O); end
      total++; if (DAT_O !== 32'h0) begin bad++; $display("FAIL rst_dat got=%h exp=0", DAT_O); end
      total++;
      if ({FRE_O_nd, CYC_O, STB_O, WE_O, ACK_O, BUSY_O, ERR_O} !== 7'b0) begin
         bad++;
         $display("FAIL rst_flags got=%b exp=0", {FRE_O_nd, CYC_O, STB_O, WE_O, ACK_O, BUSY_O, ERR_O});
      end
      @(posedge clk); #1; RST_I = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (BUSY_O !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", BUSY_O); end
   endtask

   task automatic test_average;
      logic [15:0] re [8], im [8];
      logic [31:0] expv;
      int nd0, err0;
      for (int c = 0; c < 3; c++) begin
         for (int i = 0; i < 8; i++) begin
            case (c)
               0: begin re[i] = 16'h1000; im[i] = 16'hF000; end
               1: begin im[i] = 16'h7FFF; end
               default: begin re[i] = 16'h8000; im[i] = (i < 7) ? 16'h0001 : 16'h0000; end
            endcase
         end
         if (c == 1) re = '{16'h0003, 16'hFFFC, 16'h0001, 16'hFFFF, 16'h0002, 16'hFFFE, 16'h0005, 16'hFFFB};
         expv = {avg8(im), avg8(re)};
         nd0 = nd_cnt; err0 = err_cnt;
         preamble(re, im, (c == 0), 1'b0);
         run_stream(0, -1, -1, 1'b0, 32'h0);
         total++; if (busy_at_sync !== 1'b0) begin bad++; $display("FAIL avg_busy_t got=%b exp=0", busy_at_sync); end
         total++; if (busy_after_sync !== 1'b1) begin bad++; $display("FAIL avg_busy_t1 got=%b exp=1", busy_after_sync); end
         total++; if (nd_cnt - nd0 != 1) begin bad++; $display("FAIL avg_nd_cnt got=%0d exp=1", nd_cnt - nd0); end
         total++; if (nd_val !== expv) begin bad++; $display("FAIL avg_val%0d got=%h exp=%h", c, nd_val, expv); end
         total++; if (nd_cyc - last_met_cyc != 1) begin bad++; $display("FAIL avg_lat got=%0d exp=1", nd_cyc - last_met_cyc); end
         total++; if (FRE_O !== expv) begin bad++; $display("FAIL avg_hold got=%h exp=%h", FRE_O, expv); end
         total++; if (err_cnt - err0 != 1) begin bad++; $display("FAIL avg_err got=%0d exp=1", err_cnt - err0); end
         total++; if (to_flag || ack_cnt != 0) begin bad++; $display("FAIL avg_acks got=%0d/%0d exp=0/0", ack_cnt, to_flag); end
      end
   endtask

   task automatic test_full_frame;
      logic [15:0] re [8], im [8];
      int nd0, err0;
      for (int i = 0; i < 8; i++) begin re[i] = 16'($urandom); im[i] = 16'($urandom); end
      nd0 = nd_cnt; err0 = err_cnt;
      preamble(re, im, 1'b0, 1'b0);
      run_stream(-1, -1, -1, 1'b0, 32'h0001_0000);
      total++; if (to_flag) begin bad++; $display("FAIL ff_timeout got=1 exp=0"); end
      total++; if (ack_cnt != FRAME) begin bad++; $display("FAIL ff_acks got=%0d exp=%0d", ack_cnt, FRAME); end
      total++; if (ds_cnt != FRAME) begin bad++; $display("FAIL ff_ds got=%0d exp=%0d", ds_cnt, FRAME); end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL ff_left got=%0d exp=0", exp_q.size()); end
      total++; if (last_ack - first_ack != FRAME - 1) begin bad++; $display("FAIL ff_bubbles got=%0d exp=%0d", last_ack - first_ack, FRAME - 1); end
      total++; if (rise_cyc - nd_cyc != WAITC + 1) begin bad++; $display("FAIL ff_cyc_rise got=%0d exp=%0d", rise_cyc - nd_cyc, WAITC + 1); end
      total++; if (first_ack - nd_cyc != WAITC + 1) begin bad++; $display("FAIL ff_ack_open got=%0d exp=%0d", first_ack - nd_cyc, WAITC + 1); end
      total++; if (fall_cyc - last_xfer != 1) begin bad++; $display("FAIL ff_cyc_fall got=%0d exp=1", fall_cyc - last_xfer); end
      total++; if (nd_val !== {avg8(im), avg8(re)}) begin bad++; $display("FAIL ff_avg got=%h exp=%h", nd_val, {avg8(im), avg8(re)}); end
      total++; if (err_cnt != err0 || nd_cnt - nd0 != 1) begin bad++; $display("FAIL ff_events got=%0d/%0d exp=0/1", err_cnt - err0, nd_cnt - nd0); end
      total++; if (we_bad != 0) begin bad++; $display("FAIL ff_we got=%0d exp=0", we_bad); end
   endtask

   task automatic test_backpressure;
      logic [15:0] re [8], im [8];
      for (int i = 0; i < 8; i++) begin re[i] = 16'(i * 100); im[i] = 16'(-i); end
      preamble(re, im, 1'b0, 1'b0);
      run_stream(-1, 1000, -1, 1'b0, 32'hA000_0000);
      total++; if (to_flag) begin bad++; $display("FAIL bp_timeout got=1 exp=0"); end
      total++; if (stall_bad != 0) begin bad++; $display("FAIL bp_stall got=%0d exp=0", stall_bad); end
      total++; if (ack_cnt != FRAME || ds_cnt != FRAME) begin bad++; $display("FAIL bp_count got=%0d/%0d exp=%0d", ack_cnt, ds_cnt, FRAME); end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bp_left got=%0d exp=0", exp_q.size()); end
   endtask

   task automatic test_abort;
      logic [15:0] re [8], im [8];
      int err0;
      for (int i = 0; i < 8; i++) begin re[i] = 16'h0100; im[i] = 16'h0200; end
      err0 = err_cnt;
      preamble(re, im, 1'b0, 1'b0);
      run_stream(100, 100, -1, 1'b0, 32'h5500_0000);
      total++; if (to_flag) begin bad++; $display("FAIL ab_timeout got=1 exp=0"); end
      total++; if (err_cnt - err0 != 1) begin bad++; $display("FAIL ab_err got=%0d exp=1", err_cnt - err0); end
      total++; if (ack_cnt != 100 || ds_cnt != 100) begin bad++; $display("FAIL ab_count got=%0d/%0d exp=100", ack_cnt, ds_cnt); end
      total++; if (stall_bad != 0) begin bad++; $display("FAIL ab_hold got=%0d exp=0", stall_bad); end
      total++; if (fall_cyc - last_xfer != 1) begin bad++; $display("FAIL ab_cyc_fall got=%0d exp=1", fall_cyc - last_xfer); end
      @(negedge clk);
      total++; if (BUSY_O !== 1'b0 || CYC_O !== 1'b0) begin bad++; $display("FAIL ab_idle got=%b%b exp=00", BUSY_O, CYC_O); end
   endtask

   task automatic test_ignored;
      logic [15:0] re [8], im [8];
      int nd0, err0;
      for (int i = 0; i < 8; i++) begin re[i] = 16'hFFF8; im[i] = 16'h0010; end
      nd0 = nd_cnt; err0 = err_cnt;
      preamble(re, im, 1'b1, 1'b1);
      run_stream(-1, -1, -1, 1'b1, 32'h00C0_0000);
      total++; if (nd_cnt - nd0 != 1) begin bad++; $display("FAIL ig_nd got=%0d exp=1", nd_cnt - nd0); end
      total++; if (FRE_O !== 32'h0010FFF8) begin bad++; $display("FAIL ig_fre got=%h exp=0010fff8", FRE_O); end
      total++; if (ack_cnt != FRAME || ds_cnt != FRAME) begin bad++; $display("FAIL ig_count got=%0d/%0d exp=%0d", ack_cnt, ds_cnt, FRAME); end
      total++; if (err_cnt != err0 || to_flag) begin bad++; $display("FAIL ig_err got=%0d exp=0", err_cnt - err0); end
      repeat (3) @(negedge clk);
      total++; if (BUSY_O !== 1'b0) begin bad++; $display("FAIL ig_idle got=%b exp=0", BUSY_O); end
   endtask

   task automatic test_reset_mid;
      logic [15:0] re [8], im [8];
      int nd0;
      for (int i = 0; i < 8; i++) begin re[i] = 16'h0400; im[i] = 16'hFC00; end
      preamble(re, im, 1'b0, 1'b0);
      run_stream(-1, -1, 500, 1'b0, 32'h7700_0000);
      total++; if (rst_snap !== 72'h0) begin bad++; $display("FAIL rm_outputs got=%h exp=0", rst_snap); end
      total++; if (to_flag) begin bad++; $display("FAIL rm_timeout got=1 exp=0"); end
      nd0 = nd_cnt;
      for (int i = 0; i < 8; i++) begin re[i] = 16'(i); im[i] = 16'(i * 2); end
      preamble(re, im, 1'b0, 1'b0);
      run_stream(-1, -1, -1, 1'b0, 32'h3300_0000);
      total++; if (nd_cnt - nd0 != 1 || nd_val !== {avg8(im), avg8(re)}) begin bad++; $display("FAIL rm_avg got=%h exp=%h", nd_val, {avg8(im), avg8(re)}); end
      total++; if (ack_cnt != FRAME || ds_cnt != FRAME || to_flag) begin bad++; $display("FAIL rm_count got=%0d/%0d exp=%0d", ack_cnt, ds_cnt, FRAME); end
      total++; if (rise_cyc - nd_cyc != WAITC + 1) begin bad++; $display("FAIL rm_rise got=%0d exp=%0d", rise_cyc - nd_cyc, WAITC + 1); end
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_average();
      test_full_frame();
      test_backpressure();
      test_abort();
      test_ignored();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
